instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO depth in entries; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  encode request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_alucontrol  input  3  ALU control code to encode back into an R-type funct.
REQ-007 req_rs, req_rt, req_rd  input  5 each  register fields.
REQ-008 flush  input  1  synchronous clear of the FIFO and address counter.
REQ-009 out_valid  output  1  an encoded word is at the FIFO head.
REQ-010 out_ready  input  1  consumer (instruction-memory loader) takes the head word.
REQ-011 out_instr  output  32  encoded MIPS R-type instruction word.
REQ-012 out_addr  output  6  instruction-memory word address tagged on the word.
REQ-013 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-014 A handshake occurs when req_valid and req_ready are both 1; req_ready SHALL be 1 only when the FIFO is not full and flush is 0.
REQ-015 Encoding SHALL be: opcode 000000, rs in [25:21], rt in [20:16], rd in [15:11], shamt 0, funct from req_alucontrol.
REQ-016 The funct mapping SHALL be: 010 to F_ADD (0x20), 110 to F_SUB (0x22), 000 to F_AND (0x24), 001 to F_OR (0x25), 111 to F_SLT (0x2A).
REQ-017 Codes 011, 100 and 101 SHALL NOT be enqueued; err SHALL pulse high in the cycle after the handshake, and the address counter SHALL NOT advance.
REQ-018 An accepted valid word SHALL be tagged with the current address counter value, after which the counter increments modulo 64 (63 wraps to 0).
REQ-019 Latency: an accepted word SHALL appear on out_* no earlier than the next cycle, because the FIFO output is registered.
REQ-020 A pop occurs when out_valid and out_ready are both 1; while out_valid is 1 and out_ready is 0, out_instr and out_addr SHALL hold stable.
REQ-021 When the FIFO is empty, out_valid, out_instr and out_addr SHALL be 0.
REQ-022 When full, req_ready SHALL be 0 even if a pop occurs in the same cycle; the pop completes and req_ready rises in the next cycle.
REQ-023 A simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the occupancy unchanged and preserve order.
REQ-024 flush SHALL take priority over push and pop: FIFO emptied and address counter set to 0 at the next edge; out_valid is 0 in the following cycle.
REQ-025 The FIFO SHALL be a state machine with states EMPTY, PARTIAL and FULL, with transitions determined solely by push, pop and flush.

Reset
REQ-026 Asserting reset SHALL immediately clear the FIFO, the address counter and the err pulse, and drive out_valid, out_instr, out_addr, err and req_ready to 0.
REQ-027 Reset asserted mid-transfer SHALL discard all queued words; req_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-028 With INSTR_ENC_STATS_EN defined, the block SHALL add outputs enc_count (16 bits, counting accepted valid words) and rej_count (8 bits, counting rejections), both saturating, cleared by reset, and not cleared by flush.
REQ-029 Without INSTR_ENC_STATS_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-030 funct_t (F_ADD, F_SUB, F_AND, F_OR, F_SLT), the R-type opcode constant and the alucontrol code constants SHALL reside in package mips_decls_p and be shared with the ALU decoder.
REQ-031 The FIFO SHALL be the sub-module enc_fifo, parameterised by DEPTH and width 38 (32-bit instruction plus 6-bit address).

Verification
REQ-032 Send alucontrol 010 with rs=1, rt=2, rd=3 and out_ready=1 -> out_instr 0x00221820, out_addr 0, out_valid high for exactly one cycle.
REQ-033 Send 110 with rs=4, rt=5, rd=6, then 111 with rs=0, rt=0, rd=1 -> 0x00853022 at addr 0, then 0x0000082A at addr 1.
REQ-034 Send code 101 -> err pulses once, nothing is enqueued, and the next valid word still gets address 0.
REQ-035 With out_ready=0, send 5 requests at DEPTH=4 -> req_ready drops after 4; raise out_ready -> 4 words drain in order at addrs 0-3, then the 5th is accepted at addr 4.
REQ-036 Send 65 valid requests -> the 65th word has out_addr 0 (wrap); with STATS enabled, enc_count=65.
REQ-037 Assert flush with 3 words queued and req_valid=1 -> the request is dropped, out_valid is 0 the next cycle, and the next word gets addr 0; assert reset mid-drain -> outputs 0 immediately.

Source files
------------

// File: rtl/mips_decls_p.sv
// Shared MIPS declarations: R-type opcode, funct codes, ALU control codes,
// the encode FIFO state type, and the ALU-control-to-funct helper.
// Used by the instruction encoder and by the ALU decoder.
package mips_decls_p;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // Encoded word width: 32-bit instruction plus 6-bit memory word address
  localparam int ENC_W = 38;

  typedef enum logic [5:0] {
    F_ADD = 6'h20,
    F_SUB = 6'h22,
    F_AND = 6'h24,
    F_OR  = 6'h25,
    F_SLT = 6'h2A
  } funct_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  typedef struct packed {
    logic   ok;
    funct_t funct;
  } funct_enc_t;

  // Maps an ALU control code back to its R-type funct; codes with no
  // R-type equivalent come back with ok cleared.
  function automatic funct_enc_t alu_to_funct(input logic [2:0] aluc);
    funct_enc_t r;
    r.ok    = 1'b1;
    r.funct = F_ADD;
    case (aluc)
      ALUC_ADD: r.funct = F_ADD;
      ALUC_SUB: r.funct = F_SUB;
      ALUC_AND: r.funct = F_AND;
      ALUC_OR:  r.funct = F_OR;
      ALUC_SLT: r.funct = F_SLT;
      default:  r.ok    = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rtype_word(input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd,
                                             input funct_t     funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Encoded-word FIFO. Occupancy is tracked by an EMPTY/PARTIAL/FULL state
// machine driven only by push, pop and flush. Storage is flops, so a pushed
// word is visible at the head from the cycle after the push. The head reads
// as zero while empty. DEPTH must be a power of two (2..16).
module enc_fifo
  import mips_decls_p::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  fifo_state_t      state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  // Next-state: flush wins, otherwise pointers/count/state follow push and pop
  always_comb begin
    do_push  = push && (state_q != FULL);
    do_pop   = pop && (state_q != EMPTY);
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      state_d  = EMPTY;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      case (state_q)
        EMPTY: begin
          if (do_push) state_d = PARTIAL;
        end
        PARTIAL: begin
          if (do_push && !do_pop && (count_q == CNT_LAST)) state_d = FULL;
          else if (do_pop && !do_push && (count_q == CNT_ONE)) state_d = EMPTY;
        end
        FULL: begin
          if (do_pop) state_d = PARTIAL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Control registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head word and status flags
  always_comb begin
    empty = (state_q == EMPTY);
    full  = (state_q == FULL);
    rdata = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns (alucontrol, rs, rt, rd) requests into MIPS
// R-type words tagged with a 6-bit instruction-memory address and queues
// them for the memory loader. Codes with no R-type funct are rejected with
// a one-cycle err pulse and do not consume an address.
// Optional build macro INSTR_ENC_STATS_EN adds saturating enc_count and
// rej_count outputs (cleared by reset only, not by flush).
module instr_encoder
  import mips_decls_p::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_alucontrol,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [5:0]  out_addr,
  output logic        err
`ifdef INSTR_ENC_STATS_EN
  ,
  output logic [15:0] enc_count,
  output logic [7:0]  rej_count
`endif
);

  funct_enc_t       enc;
  logic             hs, push, pop;
  logic             fifo_empty, fifo_full;
  logic [ENC_W-1:0] wdata, rdata;
  logic [5:0]       addr_q, addr_d;
  logic             err_q, err_d;

  // Handshake, encoding and address/err next-state
  always_comb begin
    enc       = alu_to_funct(req_alucontrol);
    req_ready = !reset && !flush && !fifo_full;
    hs        = req_valid && req_ready;
    push      = hs && enc.ok;
    err_d     = hs && !enc.ok;
    pop       = !fifo_empty && out_ready;
    wdata     = {rtype_word(req_rs, req_rt, req_rd, enc.funct), addr_q};
    addr_d    = addr_q;
    if (flush) addr_d = '0;
    else if (push) addr_d = addr_q + 6'd1;
  end

  // Address counter and rejection pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Output mapping; rdata is already zero while the FIFO is empty
  always_comb begin
    out_valid = !fifo_empty;
    out_instr = rdata[ENC_W-1:6];
    out_addr  = rdata[5:0];
    err       = err_q;
  end

`ifdef INSTR_ENC_STATS_EN
  logic [15:0] enc_count_q, enc_count_d;
  logic [7:0]  rej_count_q, rej_count_d;

  // Saturating statistics; flush deliberately leaves them alone
  always_comb begin
    enc_count_d = enc_count_q;
    rej_count_d = rej_count_q;
    if (push && (enc_count_q != 16'hFFFF)) enc_count_d = enc_count_q + 16'd1;
    if (err_d && (rej_count_q != 8'hFF)) rej_count_d = rej_count_q + 8'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_count_q <= '0;
      rej_count_q <= '0;
    end else begin
      enc_count_q <= enc_count_d;
      rej_count_q <= rej_count_d;
    end
  end

  assign enc_count = enc_count_q;
  assign rej_count = rej_count_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4). Inputs change 2 time units
// after the rising edge; outputs are sampled on the falling edge.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_alucontrol = 3'd0;
  logic [4:0]  req_rs = 5'd0;
  logic [4:0]  req_rt = 5'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [5:0]  out_addr;
  logic        err;
`ifdef INSTR_ENC_STATS_EN
  logic [15:0] enc_count;
  logic [7:0]  rej_count;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [37:0] sb[$];
  logic [5:0]  exp_addr = 6'd0;
  int          enc_model = 0;
  int          rej_model = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_alucontrol (req_alucontrol),
    .req_rs         (req_rs),
    .req_rt         (req_rt),
    .req_rd         (req_rd),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_addr       (out_addr),
    .err            (err)
`ifdef INSTR_ENC_STATS_EN
    ,
    .enc_count      (enc_count),
    .rej_count      (rej_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // {ok, funct} from the alucontrol table
  function automatic logic [6:0] ref_funct(input logic [2:0] ac);
    case (ac)
      3'b010:  return {1'b1, 6'h20};
      3'b110:  return {1'b1, 6'h22};
      3'b000:  return {1'b1, 6'h24};
      3'b001:  return {1'b1, 6'h25};
      3'b111:  return {1'b1, 6'h2A};
      default: return 7'd0;
    endcase
  endfunction

  // Scoreboard: every pop is compared against the oldest expected word
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_word", 64'd1, 64'd0);
      end else begin
        logic [37:0] exp_w;
        exp_w = sb.pop_front();
        check_eq("word", 64'({out_instr, out_addr}), 64'(exp_w));
      end
    end
  end

  task automatic send(input logic [2:0] ac, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic use_lit = 1'b0,
                      input logic [31:0] lit = 32'd0);
    logic [6:0]  rf;
    logic [31:0] w;
    int          n;
    rf = ref_funct(ac);
    w  = use_lit ? lit : {6'b0, rs, rt, rd, 5'b0, rf[5:0]};
    @(posedge clk); #2;
    req_valid      = 1'b1;
    req_alucontrol = ac;
    req_rs         = rs;
    req_rt         = rt;
    req_rd         = rd;
    #1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    if (!req_ready) begin
      check_eq("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    if (rf[6]) begin
      sb.push_back({w, exp_addr});
      exp_addr++;
      enc_model++;
    end else begin
      rej_model++;
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    check_eq(rf[6] ? "err_idle" : "err_pulse", 64'(err), rf[6] ? 64'd0 : 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset     = 1'b1;
    req_valid = 1'b0;
    flush     = 1'b0;
    #1;
    check_eq("reset_outs", 64'({out_valid, out_instr, out_addr, err, req_ready}), 64'd0);
    sb.delete();
    exp_addr  = 6'd0;
    enc_model = 0;
    rej_model = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_eq("ready_after_reset", 64'(req_ready), 64'd1);
`ifdef INSTR_ENC_STATS_EN
    check_eq("stats_reset", 64'({enc_count, rej_count}), 64'd0);
`endif
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("drain_empty", 64'(sb.size() != 0 || out_valid), 64'd0);
  endtask

  initial begin
    int cnt;
    logic [2:0] codes [5];
    codes[0] = 3'b010; codes[1] = 3'b110; codes[2] = 3'b000;
    codes[3] = 3'b001; codes[4] = 3'b111;

    do_reset();

    // Rejected codes: single err pulse, nothing queued, no address consumed
    out_ready = 1'b1;
    send(3'b101, 5'd1, 5'd1, 5'd1);
    check_eq("rej_no_word", 64'(out_valid), 64'd0);
    @(posedge clk); #2;
    check_eq("err_single", 64'(err), 64'd0);
    send(3'b011, 5'd2, 5'd2, 5'd2);
    send(3'b100, 5'd3, 5'd3, 5'd3);

    // First valid word at address 0, visible for exactly one cycle
    send(3'b010, 5'd1, 5'd2, 5'd3, 1'b1, 32'h00221820);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check_eq("valid_one_cycle", 64'(cnt), 64'd1);
    check_eq("empty_zero", 64'({out_valid, out_instr, out_addr}), 64'd0);
`ifdef INSTR_ENC_STATS_EN
    check_eq("rej_count", 64'(rej_count), 64'(rej_model));
`endif

    // SUB then SLT at consecutive addresses
    do_reset();
    out_ready = 1'b1;
    send(3'b110, 5'd4, 5'd5, 5'd6, 1'b1, 32'h00853022);
    send(3'b111, 5'd0, 5'd0, 5'd1, 1'b1, 32'h0000082A);
    wait_drain();

    // Fill to full with consumer stalled, hold, then drain and accept the 5th
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(codes[i], 5'(i + 8), 5'(i + 16), 5'(i + 24));
    #1;
    check_eq("full_ready_low", 64'(req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("head_hold", 64'({out_valid, out_instr, out_addr}), 64'({1'b1, sb[0]}));
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    #1;
    check_eq("full_pop_ready_low", 64'(req_ready), 64'd0);
    send(3'b111, 5'd31, 5'd30, 5'd29);
    wait_drain();

    // 65 words: address wraps to 0 on the last one
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65; i++) send(codes[i % 5], 5'(i % 32), 5'((i + 7) % 32), 5'((i + 13) % 32));
    wait_drain();
`ifdef INSTR_ENC_STATS_EN
    check_eq("enc_count_65", 64'(enc_count), 64'(enc_model));
`endif

    // Flush with words queued and a request pending
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(codes[i + 1], 5'(i), 5'(i + 1), 5'(i + 2));
    @(posedge clk); #2;
    req_valid      = 1'b1;
    req_alucontrol = 3'b010;
    flush          = 1'b1;
    #1;
    check_eq("flush_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #2;
    flush     = 1'b0;
    req_valid = 1'b0;
    sb.delete();
    exp_addr = 6'd0;
    @(negedge clk);
    check_eq("flush_empty", 64'({out_valid, out_instr, out_addr}), 64'd0);
`ifdef INSTR_ENC_STATS_EN
    check_eq("enc_count_flush", 64'(enc_count), 64'(enc_model));
`endif
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(3'b001, 5'd9, 5'd10, 5'd11);
    wait_drain();

    // Reset in the middle of a drain
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(codes[4 - i], 5'(i + 20), 5'(i + 3), 5'(i + 5));
    @(posedge clk); #2;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_reset_empty", 64'({out_valid, out_instr, out_addr}), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
